// File: rtl/instruction_fetch_unit.sv
// Purpose : sequential instruction fetch with a small pc+instr FIFO towards decode; redirect flushes and restarts fetch.
// Latency : a response accepted at edge N is on deq_* after edge N; at most one fetch per 2 cycles (WAIT + ACTIVE).
// Backpres: a full queue with no dequeue holds imem_pc and ignores imem_valid until room appears.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   imem_pc / imem_instr / imem_valid   instruction-memory fetch interface (this block is the requester)
//   redirect / redirect_pc   flush the queue and restart fetch at the word-aligned redirect_pc
//   deq_valid / deq_ready    head-of-queue handshake to decode
//   deq_pc / deq_instr       head entry, combinational from storage
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        imem_valid,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        deq_valid,
    input  logic        deq_ready,
    output logic [31:0] deq_instr,
    output logic [31:0] deq_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {
        S_WAIT   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t         state;
    logic [AW-1:0]  head;
    logic [AW-1:0]  tail;
    logic [CW-1:0]  count;
    logic [31:0]    pc_q    [DEPTH];
    logic [31:0]    instr_q [DEPTH];

    logic           pop;
    logic           room;
    logic           push;
    logic [31:0]    redirect_pc_aligned;

    assign deq_valid = (count != '0);
    assign deq_pc    = pc_q[head];
    assign deq_instr = instr_q[head];

    assign pop  = deq_valid & deq_ready;
    // A full queue still has room when the head leaves in the same cycle.
    assign room = (count < FULL) | pop;
    // Redirect discards whatever response is on the bus in its cycle.
    assign push = (state == S_ACTIVE) & imem_valid & room & ~redirect;

    assign redirect_pc_aligned = redirect_pc & ~32'h3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_pc <= RESET_PC;
            state   <= S_WAIT;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (redirect) begin
            // Storage contents are left in place; count=0 makes them invisible.
            imem_pc <= redirect_pc_aligned;
            state   <= S_WAIT;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            case (state)
                // The memory needs one cycle to respond to a new address.
                S_WAIT:   state <= S_ACTIVE;
                S_ACTIVE: begin
                    if (push) begin
                        imem_pc <= imem_pc + 32'd4;
                        state   <= S_WAIT;
                    end
                end
                default:  state <= S_WAIT;
            endcase

            if (push) begin
                pc_q[tail]    <= imem_pc;
                instr_q[tail] <= imem_instr;
                tail          <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule
